// File: rtl/snn_pkg.sv
// Shared constants and types for the image spike encoder.
package snn_pkg;

  localparam int N               = 256;
  localparam int M               = 8;
  localparam int IMAGE_SIZE      = 256;
  localparam int PIXEL_MAX_VALUE = 255;
  localparam int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE);
  localparam int TIMESTEPS       = 16;
  localparam int TS_BITS         = $clog2(TIMESTEPS);
  localparam int SPIKE_CNT_BITS  = PIXEL_BITS + TS_BITS + M;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    EMIT,
    TICK,
    FIN
  } enc_state_t;

  // One address event: a spike at addr, or an end-of-timestep marker
  typedef struct packed {
    logic [M-1:0] addr;
    logic         tick;
  } evt_t;

endpackage

// File: rtl/spike_event_skid.sv
// One-deep valid/ready output register for encoder events. Once loaded,
// the event stays stable until the consumer accepts it.
module spike_event_skid
  import snn_pkg::*;
(
  input  logic ACLK,
  input  logic ARESETN,
  input  logic load,
  input  evt_t evt_in,
  input  logic ready,
  output logic valid,
  output evt_t evt_out
);

  // Load a new event, or retire the held one when it is accepted
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      valid   <= 1'b0;
      evt_out <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      evt_out <= evt_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/image_spike_encoder.sv
// Rate-coding image encoder. Each pixel owns a phase accumulator; a carry
// out on the accumulator produces a spike event for that pixel. Every full
// scan of the image ends with a tick event.
// Optional macro ENCODER_SPIKE_COUNT_EN adds a saturating SPIKE_COUNT output.
module image_spike_encoder
  import snn_pkg::*;
(
  input  logic                                  ACLK,
  input  logic                                  ARESETN,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  input  logic                                  NEW_IMAGE,
  output logic [M-1:0]                          EVT_ADDR,
  output logic                                  EVT_TICK,
  output logic                                  EVT_VALID,
  input  logic                                  EVT_READY,
  output logic                                  BUSY,
  output logic                                  DONE
`ifdef ENCODER_SPIKE_COUNT_EN
  ,
  output logic [SPIKE_CNT_BITS-1:0]             SPIKE_COUNT
`endif
);

  localparam logic [M-1:0]       LAST_PIX = M'(IMAGE_SIZE - 1);
  localparam logic [TS_BITS-1:0] LAST_TS  = TS_BITS'(TIMESTEPS - 1);

  enc_state_t state, next_state;
  logic                  new_q;
  logic                  start;
  logic [M-1:0]          pix;
  logic [TS_BITS-1:0]    ts;
  logic [PIXEL_BITS-1:0] img [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0] acc [IMAGE_SIZE];
  logic [PIXEL_BITS:0]   sum;
  logic                  handshake;
  logic                  load_img;
  logic                  acc_we;
  logic                  pix_step;
  logic                  tick_done;
  logic                  skid_load;
  evt_t                  skid_in;
  evt_t                  skid_out;

  assign start     = NEW_IMAGE & ~new_q;
  assign sum       = {1'b0, acc[pix]} + {1'b0, img[pix]};
  assign handshake = EVT_VALID & EVT_READY;
  assign BUSY      = (state != IDLE) && (state != FIN);
  assign DONE      = (state == FIN);
  assign EVT_ADDR  = skid_out.addr;
  assign EVT_TICK  = skid_out.tick;

  // State, edge-detect register and scan position counters
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
      new_q <= 1'b0;
      pix   <= '0;
      ts    <= '0;
    end else begin
      state <= next_state;
      new_q <= NEW_IMAGE;
      if (load_img) begin
        pix <= '0;
        ts  <= '0;
      end else if (tick_done) begin
        pix <= '0;
        ts  <= ts + 1'b1;
      end else if (pix_step && (pix != LAST_PIX)) begin
        pix <= pix + 1'b1;
      end
    end
  end

  // Image snapshot and phase accumulators; LOAD reinitialises both
  always_ff @(posedge ACLK) begin
    if (load_img) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        img[i] <= IMAGE[i];
        acc[i] <= '0;
      end
    end else if (acc_we) begin
      acc[pix] <= sum[PIXEL_BITS-1:0];
    end
  end

  // Next-state and control decode; leaving the last pixel queues the tick
  always_comb begin
    next_state = state;
    load_img   = 1'b0;
    acc_we     = 1'b0;
    pix_step   = 1'b0;
    tick_done  = 1'b0;
    skid_load  = 1'b0;
    skid_in    = '0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        load_img   = 1'b1;
        next_state = SCAN;
      end
      SCAN: begin
        if (sum[PIXEL_BITS]) begin
          skid_load    = 1'b1;
          skid_in.addr = pix;
          next_state   = EMIT;
        end else begin
          acc_we   = 1'b1;
          pix_step = 1'b1;
          if (pix == LAST_PIX) begin
            skid_load    = 1'b1;
            skid_in.tick = 1'b1;
            next_state   = TICK;
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          acc_we   = 1'b1;
          pix_step = 1'b1;
          if (pix == LAST_PIX) begin
            skid_load    = 1'b1;
            skid_in.tick = 1'b1;
            next_state   = TICK;
          end else begin
            next_state = SCAN;
          end
        end
      end
      TICK: begin
        if (handshake) begin
          tick_done  = 1'b1;
          next_state = (ts == LAST_TS) ? FIN : SCAN;
        end
      end
      FIN: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  spike_event_skid u_skid (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .load    (skid_load),
    .evt_in  (skid_in),
    .ready   (EVT_READY),
    .valid   (EVT_VALID),
    .evt_out (skid_out)
  );

`ifdef ENCODER_SPIKE_COUNT_EN
  logic [SPIKE_CNT_BITS-1:0] spike_count;
  assign SPIKE_COUNT = spike_count;

  // Count accepted spike events, saturating at all-ones
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      spike_count <= '0;
    end else if (load_img) begin
      spike_count <= '0;
    end else if ((state == EMIT) && handshake && (spike_count != '1)) begin
      spike_count <= spike_count + 1'b1;
    end
  end
`else
  localparam bit SPIKE_COUNT_PRESENT = 1'b0;
`endif

endmodule

// File: tb/tb_image_spike_encoder.sv
// Directed self-checking bench for image_spike_encoder.
module tb_image_spike_encoder;
  import snn_pkg::*;

  logic                                  ACLK;
  logic                                  ARESETN;
  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE;
  logic                                  NEW_IMAGE;
  logic [M-1:0]                          EVT_ADDR;
  logic                                  EVT_TICK;
  logic                                  EVT_VALID;
  logic                                  EVT_READY;
  logic                                  BUSY;
  logic                                  DONE;
`ifdef ENCODER_SPIKE_COUNT_EN
  logic [SPIKE_CNT_BITS-1:0]             SPIKE_COUNT;
`endif

  int errors = 0;
  int checks = 0;

  // Monitor state
  int          spike_cnt  [IMAGE_SIZE];
  logic [15:0] spike_mask [IMAGE_SIZE];
  int          tick_cnt, done_cnt, cur_ts, last_addr, stall_viol, order_err;
  bit          stalled;
  logic [M-1:0] st_addr;
  logic        st_tick;

  image_spike_encoder dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .IMAGE     (IMAGE),
    .NEW_IMAGE (NEW_IMAGE),
    .EVT_ADDR  (EVT_ADDR),
    .EVT_TICK  (EVT_TICK),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .BUSY      (BUSY),
    .DONE      (DONE)
`ifdef ENCODER_SPIKE_COUNT_EN
    ,
    .SPIKE_COUNT (SPIKE_COUNT)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Record accepted events, stall stability, ordering and DONE pulses
  always @(negedge ACLK) begin
    if (DONE) done_cnt++;
    if (stalled && ARESETN) begin
      if (!EVT_VALID || EVT_ADDR !== st_addr || EVT_TICK !== st_tick) stall_viol++;
    end
    stalled = ARESETN && EVT_VALID && !EVT_READY;
    st_addr = EVT_ADDR;
    st_tick = EVT_TICK;
    if (ARESETN && EVT_VALID && EVT_READY) begin
      if (EVT_TICK) begin
        tick_cnt++;
        if (EVT_ADDR !== '0) order_err++;
        cur_ts++;
        last_addr = -1;
      end else begin
        spike_cnt[EVT_ADDR]++;
        if (cur_ts < 16) spike_mask[EVT_ADDR][cur_ts[3:0]] = 1'b1;
        if (int'(EVT_ADDR) <= last_addr) order_err++;
        last_addr = int'(EVT_ADDR);
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      spike_cnt[i]  = 0;
      spike_mask[i] = '0;
    end
    tick_cnt   = 0;
    done_cnt   = 0;
    cur_ts     = 0;
    last_addr  = -1;
    stall_viol = 0;
    order_err  = 0;
    stalled    = 0;
  endtask

  function automatic int total_spikes();
    int s = 0;
    for (int i = 0; i < IMAGE_SIZE; i++) s += spike_cnt[i];
    return s;
  endfunction

  // Step until DONE is seen at a falling edge; cycles counts rising edges
  task automatic run_to_done(input int max_cycles, input bit bp, input bit drop_new,
                             output int cycles);
    bit seen = 0;
    cycles = 0;
    EVT_READY = (bp && $urandom_range(0, 9) >= 3) ? 1'b0 : 1'b1;
    while (!seen && cycles <= max_cycles) begin
      @(negedge ACLK);
      if (DONE) seen = 1;
      else begin
        @(posedge ACLK);
        #1;
        cycles++;
        if (drop_new) NEW_IMAGE = 1'b0;
        EVT_READY = (bp && $urandom_range(0, 9) >= 3) ? 1'b0 : 1'b1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL done_timeout: got no DONE within %0d cycles", max_cycles);
    end
  endtask

  task automatic settle();
    step();
    EVT_READY = 1'b1;
    step();
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) step();
    @(negedge ACLK);
    checks++; if (EVT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0b expected 0", EVT_VALID); end
    checks++; if (EVT_TICK !== 1'b0) begin errors++; $display("[TB] FAIL rst_tick: got %0b expected 0", EVT_TICK); end
    checks++; if (EVT_ADDR !== '0) begin errors++; $display("[TB] FAIL rst_addr: got %0d expected 0", EVT_ADDR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %0b expected 0", DONE); end
    step();
    ARESETN = 1'b1;
    step();
  endtask

  task automatic test_zero_image();
    int n;
    IMAGE = '0;
    clear_mon();
    NEW_IMAGE = 1'b1;
    run_to_done(6000, 0, 1, n);
    settle();
    checks++; if (n !== 4114) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 4114", n); end
    checks++; if (tick_cnt !== 16) begin errors++; $display("[TB] FAIL zero_ticks: got %0d expected 16", tick_cnt); end
    checks++; if (total_spikes() !== 0) begin errors++; $display("[TB] FAIL zero_spikes: got %0d expected 0", total_spikes()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL zero_done: got %0d expected 1", done_cnt); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %0b expected 0", BUSY); end
  endtask

  task automatic test_half_pixel();
    int n;
    IMAGE = '0;
    IMAGE[5] = 8'd128;
    clear_mon();
    NEW_IMAGE = 1'b1;
    run_to_done(6000, 0, 1, n);
    settle();
    checks++; if (n !== 4122) begin errors++; $display("[TB] FAIL half_latency: got %0d expected 4122", n); end
    checks++; if (spike_cnt[5] !== 8) begin errors++; $display("[TB] FAIL half_count: got %0d expected 8", spike_cnt[5]); end
    checks++; if (spike_mask[5] !== 16'hAAAA) begin errors++; $display("[TB] FAIL half_mask: got %h expected aaaa", spike_mask[5]); end
    checks++; if (total_spikes() !== 8) begin errors++; $display("[TB] FAIL half_total: got %0d expected 8", total_spikes()); end
    checks++; if (tick_cnt !== 16) begin errors++; $display("[TB] FAIL half_ticks: got %0d expected 16", tick_cnt); end
`ifdef ENCODER_SPIKE_COUNT_EN
    checks++; if (SPIKE_COUNT !== SPIKE_CNT_BITS'(8)) begin errors++; $display("[TB] FAIL half_spike_count: got %0d expected 8", SPIKE_COUNT); end
`endif
  endtask

  task automatic test_extremes();
    int n;
    IMAGE = '0;
    IMAGE[0]   = 8'd255;
    IMAGE[255] = 8'd16;
    clear_mon();
    NEW_IMAGE = 1'b1;
    run_to_done(6000, 0, 1, n);
    settle();
    checks++; if (spike_cnt[0] !== 15) begin errors++; $display("[TB] FAIL ext_p0_count: got %0d expected 15", spike_cnt[0]); end
    checks++; if (spike_cnt[255] !== 1) begin errors++; $display("[TB] FAIL ext_p255_count: got %0d expected 1", spike_cnt[255]); end
    checks++; if (spike_mask[0] !== 16'hFFFE) begin errors++; $display("[TB] FAIL ext_p0_mask: got %h expected fffe", spike_mask[0]); end
    checks++; if (spike_mask[255] !== 16'h8000) begin errors++; $display("[TB] FAIL ext_p255_mask: got %h expected 8000", spike_mask[255]); end
    checks++; if (order_err !== 0) begin errors++; $display("[TB] FAIL ext_order: got %0d errors expected 0", order_err); end
    checks++; if (tick_cnt !== 16) begin errors++; $display("[TB] FAIL ext_ticks: got %0d expected 16", tick_cnt); end
  endtask

  task automatic test_backpressure();
    int n, bad, first_bad, exp_cnt;
    int expected [IMAGE_SIZE];
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      IMAGE[i] = PIXEL_BITS'($urandom_range(0, 255));
      expected[i] = (16 * int'(IMAGE[i])) / 256;
    end
    clear_mon();
    NEW_IMAGE = 1'b1;
    run_to_done(40000, 1, 1, n);
    settle();
    bad = 0;
    first_bad = -1;
    exp_cnt = 0;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      if (spike_cnt[i] != expected[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (first_bad >= 0) exp_cnt = expected[first_bad];
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL bp_counts: %0d pixels wrong, first %0d got %0d expected %0d", bad, first_bad, spike_cnt[first_bad], exp_cnt); end
    checks++; if (stall_viol !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes while stalled expected 0", stall_viol); end
    checks++; if (order_err !== 0) begin errors++; $display("[TB] FAIL bp_order: got %0d errors expected 0", order_err); end
    checks++; if (tick_cnt !== 16) begin errors++; $display("[TB] FAIL bp_ticks: got %0d expected 16", tick_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL bp_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_retrigger();
    int n;
    IMAGE = '0;
    IMAGE[5] = 8'd128;
    clear_mon();
    NEW_IMAGE = 1'b1;
    EVT_READY = 1'b1;
    repeat (1000) step();
    NEW_IMAGE = 1'b0;
    step();
    NEW_IMAGE = 1'b1;
    for (int i = 0; i < IMAGE_SIZE; i++) IMAGE[i] = 8'd255;
    run_to_done(8000, 0, 0, n);
    settle();
    checks++; if (spike_cnt[5] !== 8) begin errors++; $display("[TB] FAIL retrig_count: got %0d expected 8", spike_cnt[5]); end
    checks++; if (total_spikes() !== 8) begin errors++; $display("[TB] FAIL retrig_total: got %0d expected 8", total_spikes()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL retrig_done: got %0d expected 1", done_cnt); end
    repeat (10) step();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL retrig_level: got busy %0b expected 0", BUSY); end
    NEW_IMAGE = 1'b0;
    step();
    clear_mon();
    NEW_IMAGE = 1'b1;
    run_to_done(12000, 0, 1, n);
    settle();
    checks++; if (total_spikes() !== 3840) begin errors++; $display("[TB] FAIL rerun_total: got %0d expected 3840", total_spikes()); end
    checks++; if (n !== 7954) begin errors++; $display("[TB] FAIL rerun_latency: got %0d expected 7954", n); end
  endtask

  task automatic test_reset_mid_emit();
    int n;
    bit found = 0;
    bit rdy_next;
    IMAGE = '0;
    IMAGE[5] = 8'd128;
    clear_mon();
    NEW_IMAGE = 1'b1;
    EVT_READY = 1'b0;
    step();
    NEW_IMAGE = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge ACLK);
      if (EVT_VALID && !EVT_TICK) found = 1;
      else begin
        rdy_next = EVT_VALID && EVT_TICK;
        step();
        EVT_READY = rdy_next;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL emit_timeout: got no spike event expected one"); end
    step();
    ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    checks++; if (EVT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %0b expected 0", EVT_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %0b expected 0", BUSY); end
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    EVT_READY = 1'b1;
    step();
    clear_mon();
    NEW_IMAGE = 1'b1;
    run_to_done(6000, 0, 1, n);
    settle();
    checks++; if (spike_cnt[5] !== 8) begin errors++; $display("[TB] FAIL post_rst_count: got %0d expected 8", spike_cnt[5]); end
    checks++; if (spike_mask[5] !== 16'hAAAA) begin errors++; $display("[TB] FAIL post_rst_mask: got %h expected aaaa", spike_mask[5]); end
    checks++; if (tick_cnt !== 16) begin errors++; $display("[TB] FAIL post_rst_ticks: got %0d expected 16", tick_cnt); end
  endtask

  initial begin
    ARESETN   = 1'b0;
    NEW_IMAGE = 1'b0;
    EVT_READY = 1'b1;
    IMAGE     = '0;
    clear_mon();
    test_reset();
    test_zero_image();
    test_half_pixel();
    test_extremes();
    test_backpressure();
    test_retrigger();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
